rv32i_multicycle_controller: RTL and testbench

Parametrised control unit for the RV32I multicycle core. It decodes the latched instruction and drives every datapath select and write enable from a Moore-style main FSM. It extends the basic lw/sw/R/I controller with:
- full RV32I control flow (all six branches, JAL, JALR, LUI, AUIPC)
- a variable-latency memory handshake
- `ena`-based stalling
- an illegal-instruction halt state

It sits between the instruction register and the datapath muxes inside `rv32i_multicycle_core`.

---
 rtl/alu_types.sv | 7 +
 rtl/rv32i_ctrl_pkg.sv | 31 +++
 rtl/rv32i_alu_decoder.sv | 30 +++
 rtl/rv32i_multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_rv32i_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_types.sv
// alu_types: ALU operation encoding shared across the core
package alu_types;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;
endpackage

// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: controller states, datapath select encodings and opcodes
package rv32i_ctrl_pkg;
    typedef alu_types::alu_control_t alu_control_t;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WRITE, S_MEM_WB,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI,
        S_AUIPC, S_HALT
    } state_t;
    typedef enum logic {ADR_PC, ADR_RESULT} adr_src_t;
    typedef enum logic [1:0] {A_PC, A_OLD_PC, A_RS1, A_ZERO} alu_a_t;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_b_t;
    typedef enum logic [1:0] {RES_ALU_OUT, RES_DATA, RES_ALU_RESULT} res_src_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
    typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_FUNCT} alu_mode_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    // Immediate format depends only on the opcode; unknown opcodes fall back to I
    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        return (op == OP_STORE) ? IMM_S :
               (op == OP_BRANCH) ? IMM_B :
               (op == OP_JAL) ? IMM_J :
               (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
    endfunction
endpackage

// File: rtl/rv32i_alu_decoder.sv
// rv32i_alu_decoder: maps op/funct3/funct7b5 and the FSM's mode to an ALU operation
module rv32i_alu_decoder
    import rv32i_ctrl_pkg::*;
    import alu_types::*;
(
    input  logic [6:0]   op_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7b5_i,
    input  alu_mode_t    mode_i,
    output alu_control_t alu_control_o
);
    alu_control_t alu_f;
    // Funct decode; SUB only exists for R-type, funct7b5 on I-type only picks SRAI
    always_comb begin
        alu_f = ALU_ADD;
        case (funct3_i)
            3'b000: alu_f = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001: alu_f = ALU_SLL;
            3'b010: alu_f = ALU_SLT;
            3'b011: alu_f = ALU_SLTU;
            3'b100: alu_f = ALU_XOR;
            3'b101: alu_f = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110: alu_f = ALU_OR;
            3'b111: alu_f = ALU_AND;
            default: alu_f = ALU_ADD;
        endcase
    end
    assign alu_control_o = (mode_i == MODE_ADD) ? ALU_ADD :
                           (mode_i == MODE_SUB) ? ALU_SUB : alu_f;
endmodule

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller: Moore FSM driving datapath selects and write enables
module rv32i_multicycle_controller
    import rv32i_ctrl_pkg::*;
    import alu_types::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic         alu_zero,
    input  logic         alu_lt,
    input  logic         alu_ltu,
    input  logic         mem_ready,
    output logic         pc_write,
    output logic         ir_write,
    output logic         mem_write,
    output logic         reg_write,
    output logic         adr_src,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   res_src,
    output logic [2:0]   imm_src,
    output alu_control_t alu_control,
    output logic         jalr_mask,
    output logic         instr_retired,
    output logic         halted
);
    state_t    state_q, state_d;
    state_t    illegal_next;
    alu_mode_t alu_mode;
    logic      rdy, live, cmp, taken;
    logic      pc_w, ir_w, mem_w, reg_w, ret;
    assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign live         = ena && !rst;
    assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
    assign cmp          = (funct3[2:1] == 2'b00) ? alu_zero :
                          (funct3[2:1] == 2'b10) ? alu_lt : alu_ltu;
    assign taken        = cmp ^ funct3[0];
    assign imm_src      = imm_src_of(op);
    // State register: reset to fetch, freeze while disabled
    always_ff @(posedge clk) begin
        state_q <= rst ? S_FETCH : (ena ? state_d : state_q);
    end
    // Next-state and per-state select/enable decode
    always_comb begin
        state_d   = state_q;
        adr_src   = ADR_PC;
        alu_src_a = A_PC;
        alu_src_b = B_RS2;
        res_src   = RES_ALU_OUT;
        alu_mode  = MODE_ADD;
        jalr_mask = 1'b0;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        ret       = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = B_FOUR;
                res_src   = RES_ALU_RESULT;
                ir_w      = rdy;
                pc_w      = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_BRANCH: state_d = (funct3[2:1] == 2'b01) ? illegal_next : S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default:   state_d = illegal_next;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                state_d   = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = ADR_RESULT;
                state_d = rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WRITE: begin
                adr_src = ADR_RESULT;
                mem_w   = 1'b1;
                ret     = rdy;
                state_d = rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_MEM_WB: begin
                res_src = RES_DATA;
                reg_w   = 1'b1;
                ret     = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = A_RS1;
                alu_mode  = MODE_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                alu_mode  = MODE_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_w   = 1'b1;
                ret     = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = A_RS1;
                alu_mode  = MODE_SUB;
                pc_w      = taken;
                ret       = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_FOUR;
                pc_w      = 1'b1;
                jalr_mask = (op == OP_JALR);
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = A_ZERO;
                alu_src_b = B_IMM;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_IMM;
                state_d   = S_ALU_WB;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end
    assign pc_write      = pc_w && live;
    assign ir_write      = ir_w && live;
    assign mem_write     = mem_w && live;
    assign reg_write     = reg_w && live;
    assign instr_retired = ret && live;
    assign halted        = (state_q == S_HALT) && !rst;
    rv32i_alu_decoder u_alu_dec (
        .op_i          (op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .mode_i        (alu_mode),
        .alu_control_o (alu_control)
    );
endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// tb_rv32i_multicycle_controller: instruction-level reference checks of the controller
module tb_rv32i_multicycle_controller;
    import alu_types::*;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [6:0] op = 7'b0010011;
    logic [2:0] funct3 = 3'b000;
    logic funct7b5 = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
    logic pc_write, ir_write, mem_write, reg_write, adr_src, jalr_mask, instr_retired, halted;
    logic [1:0] alu_src_a, alu_src_b, res_src;
    logic [2:0] imm_src;
    alu_control_t alu_control;
    int checks = 0, errors = 0;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;
    rv32i_multicycle_controller dut (
        .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .res_src(res_src),
        .imm_src(imm_src), .alu_control(alu_control), .jalr_mask(jalr_mask),
        .instr_retired(instr_retired), .halted(halted)
    );
    always #5 clk = ~clk;
    function automatic logic [6:0] op_of(input int k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_LUI:   return 7'b0110111;
            default: return 7'b0010111;
        endcase
    endfunction
    function automatic int base_lat(input int k);
        return (k == K_LW || k == K_JALR) ? 5 : (k == K_BR) ? 3 : 4;
    endfunction
    function automatic logic [2:0] exp_imm(input int k);
        return (k == K_SW) ? 3'd1 : (k == K_BR) ? 3'd2 : (k == K_JAL) ? 3'd3 :
               (k == K_LUI || k == K_AUIPC) ? 3'd4 : 3'd0;
    endfunction
    function automatic alu_control_t exp_alu(input int k, input logic [2:0] f3, input logic f7);
        if (k == K_BR) return ALU_SUB;
        if (k != K_R && k != K_I) return ALU_ADD;
        case (f3)
            3'd0: return (k == K_R && f7) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    // One instruction: fw fetch waits, dw data waits, stall_pct percent of cycles with ena=0
    task automatic run_instr(input int k, input logic [2:0] f3, input logic f7, input int fw, input int dw,
                             input int stall_pct, input bit force_flags, input logic fz, input logic fl, input logic flu);
        int L, ds, s, guard;
        logic in_f, in_d, tk;
        logic [4:0] exp_st;
        logic [11:0] exp_sel, msk, act_sel;
        logic [1:0] ea, eb;
        L = base_lat(k) + fw + ((k == K_LW || k == K_SW) ? dw : 0);
        ds = fw + 3;
        s = 0;
        guard = 0;
        op = op_of(k);
        funct3 = f3;
        funct7b5 = f7;
        ea = (k == K_LUI) ? 2'd3 : (k == K_AUIPC) ? 2'd1 : 2'd2;
        eb = (k == K_R || k == K_BR) ? 2'd0 : 2'd1;
        while (s < L && guard < 2000) begin
            @(negedge clk);
            guard++;
            ena = ($urandom_range(99) >= stall_pct);
            alu_zero = force_flags ? fz : 1'($urandom_range(1));
            alu_lt = force_flags ? fl : 1'($urandom_range(1));
            alu_ltu = force_flags ? flu : 1'($urandom_range(1));
            in_f = (s <= fw);
            in_d = (k == K_LW || k == K_SW) && s >= ds && s <= ds + dw;
            mem_ready = !ena ? 1'($urandom_range(1)) : in_f ? (s == fw) : in_d ? (s == ds + dw) : 1'($urandom_range(1));
            case (f3)
                3'd0: tk = alu_zero;
                3'd1: tk = !alu_zero;
                3'd4: tk = alu_lt;
                3'd5: tk = !alu_lt;
                3'd6: tk = alu_ltu;
                default: tk = !alu_ltu;
            endcase
            exp_st = !ena ? 5'b0 : {
                (s == fw) || (k == K_BR && s == L - 1 && tk) || ((k == K_JAL || k == K_JALR) && s == L - 2),
                s == fw,
                k == K_SW && in_d,
                s == L - 1 && k != K_SW && k != K_BR,
                s == L - 1};
            msk = 12'h000;
            exp_sel = 12'h000;
            if ((k == K_JAL || k == K_JALR) && s == L - 2) begin
                exp_sel = {1'b0, 2'd1, 2'd2, 2'd0, ALU_ADD, k == K_JALR};
                msk = 12'b0_11_11_11_1111_1;
            end else if (in_f) begin
                exp_sel = {1'b0, 2'd0, 2'd2, 2'd2, ALU_ADD, 1'b0};
                msk = 12'b1_11_11_11_1111_0;
            end else if (s == fw + 1) begin
                exp_sel = {1'b0, 2'd1, 2'd1, 2'd0, ALU_ADD, 1'b0};
                msk = 12'b0_11_11_00_1111_0;
            end else if (s == fw + 2) begin
                exp_sel = {1'b0, ea, eb, 2'd0, exp_alu(k, f3, f7), 1'b0};
                msk = 12'b0_11_11_00_1111_0;
            end else if (in_d) begin
                exp_sel = {1'b1, 2'd0, 2'd0, 2'd0, ALU_ADD, 1'b0};
                msk = 12'b1_00_00_11_0000_0;
            end else if (s == L - 1 && k != K_SW && k != K_BR) begin
                exp_sel = {1'b0, 2'd0, 2'd0, (k == K_LW) ? 2'd1 : 2'd0, ALU_ADD, 1'b0};
                msk = 12'b0_00_00_11_0000_0;
            end
            #1;
            checks++;
            if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== {exp_st, 1'b0}) begin
                errors++;
                $display("FAIL strobes kind=%0d step=%0d ena=%0b: got pc/ir/mw/rw/ret/halt=%b expected %b",
                         k, s, ena, {pc_write, ir_write, mem_write, reg_write, instr_retired, halted}, {exp_st, 1'b0});
            end
            checks++;
            if (imm_src !== exp_imm(k)) begin
                errors++;
                $display("FAIL imm_src kind=%0d: got %0d expected %0d", k, imm_src, exp_imm(k));
            end
            act_sel = {adr_src, alu_src_a, alu_src_b, res_src, alu_control, jalr_mask};
            if (msk != 12'h000) begin
                checks++;
                if ((act_sel & msk) !== (exp_sel & msk)) begin
                    errors++;
                    $display("FAIL selects kind=%0d step=%0d: got adr/a/b/res/alu/jm=%b expected %b (mask %b)",
                             k, s, act_sel, exp_sel, msk);
                end
            end
            if (ena) s++;
        end
        checks++;
        if (s != L) begin
            errors++;
            $display("FAIL timeout kind=%0d: reached step %0d of %0d", k, s, L);
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        ena = 1'b1;
        mem_ready = 1'b1;
        op = 7'b0110011;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes: got %b expected 000000",
                         {pc_write, ir_write, mem_write, reg_write, instr_retired, halted});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({pc_write, ir_write, adr_src, alu_src_a, alu_src_b, res_src, halted} !== {2'b00, 1'b0, 2'd0, 2'd2, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_fetch: got pc/ir/adr/a/b/res/halt=%b", {pc_write, ir_write, adr_src, alu_src_a, alu_src_b, res_src, halted});
        end
    endtask
    task automatic test_addi;
        run_instr(K_I, 3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_lw_wait;
        run_instr(K_LW, 3'b010, 1'b0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_sw_wait;
        run_instr(K_SW, 3'b010, 1'b0, 0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_beq;
        run_instr(K_BR, 3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr(K_BR, 3'b000, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_jalr;
        run_instr(K_JALR, 3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(K_JAL, 3'b000, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_stall;
        run_instr(K_I, 3'b101, 1'b1, 2, 0, 50, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(K_SW, 3'b000, 1'b0, 1, 2, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_mid_reset;
        op = 7'b0100011;
        ena = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_strobes: got %b expected 000000",
                     {pc_write, ir_write, mem_write, reg_write, instr_retired, halted});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_write, adr_src, alu_src_b, res_src} !== {1'b0, 1'b0, 2'd2, 2'd2}) begin
            errors++;
            $display("FAIL mid_reset_fetch: got mw/adr/b/res=%b expected 0_0_10_10", {mem_write, adr_src, alu_src_b, res_src});
        end
        run_instr(K_R, 3'b000, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_illegal;
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 7'b0000000 : 7'b1100011;
            funct3 = (i == 0) ? 3'b000 : 3'b011;
            ena = 1'b1;
            mem_ready = 1'b1;
            @(negedge clk);
            #1;
            checks++;
            if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== 6'b110000) begin
                errors++;
                $display("FAIL illegal_fetch case=%0d: got %b expected 110000", i,
                         {pc_write, ir_write, mem_write, reg_write, instr_retired, halted});
            end
            @(negedge clk);
            #1;
            checks++;
            if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== 6'b000000) begin
                errors++;
                $display("FAIL illegal_decode case=%0d: got %b expected 000000", i,
                         {pc_write, ir_write, mem_write, reg_write, instr_retired, halted});
            end
            repeat (6) begin
                @(negedge clk);
                ena = 1'($urandom_range(1));
                mem_ready = 1'b1;
                #1;
                checks++;
                if ({pc_write, ir_write, mem_write, reg_write, instr_retired, halted} !== 6'b000001) begin
                    errors++;
                    $display("FAIL halted case=%0d: got %b expected 000001", i,
                             {pc_write, ir_write, mem_write, reg_write, instr_retired, halted});
                end
            end
            @(negedge clk);
            rst = 1'b1;
            ena = 1'b1;
            #1;
            checks++;
            if (halted !== 1'b0) begin
                errors++;
                $display("FAIL halt_rst case=%0d: got halted=%b expected 0", i, halted);
            end
            @(negedge clk);
            rst = 1'b0;
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({halted, alu_src_b, res_src} !== {1'b0, 2'd2, 2'd2}) begin
                errors++;
                $display("FAIL halt_exit case=%0d: got halt/b/res=%b expected 0_10_10", i, {halted, alu_src_b, res_src});
            end
            run_instr(K_I, 3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask
    task automatic test_random;
        int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
        int k;
        logic [2:0] f3;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(8);
            f3 = (k == K_BR) ? 3'(br_f3[$urandom_range(5)]) : 3'($urandom_range(7));
            run_instr(k, f3, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3), 20,
                      1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask
    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_jalr();
        test_stall();
        test_mid_reset();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
